// File: rtl/fsm_vend_refund.sv
// Coin-operated vending controller with change and cancel refund.
// Credit accumulates to PRICE_HALVES, then dispenses and pays change back as serial coin pulses.
module fsm_vend_refund #(
   parameter int PRICE_HALVES = 3,
   parameter int CNT_W        = 4
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             pi_money_half,
   input  logic             pi_money_one,
   input  logic             pi_cancel,
   output logic             po_cola,
   output logic             po_money_one,
   output logic             po_money_half,
   output logic             po_reject,
   output logic [CNT_W-1:0] po_credit
);

   typedef enum logic {
      ACCUM  = 1'b0,
      REFUND = 1'b1
   } state_t;

   localparam logic [CNT_W:0] PRICE = (CNT_W+1)'(PRICE_HALVES);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] credit_q, credit_d;
   logic [CNT_W-1:0] change_q, change_d;
   logic             cola_d, one_d, half_d, reject_d;
   logic             coin_any, coin_bad;
   logic [CNT_W:0]   coin_val;
   logic [CNT_W:0]   sum;

   assign coin_any = pi_money_half | pi_money_one;
   assign coin_bad = pi_money_half & pi_money_one;
   assign coin_val = pi_money_one  ? (CNT_W+1)'(2) :
                     pi_money_half ? (CNT_W+1)'(1) : '0;
   // One extra bit so the completing coin can never wrap past the price.
   assign sum      = {1'b0, credit_q} + coin_val;

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
      state_d  = state_q;
      credit_d = credit_q;
      change_d = change_q;
      cola_d   = 1'b0;
      one_d    = 1'b0;
      half_d   = 1'b0;
      reject_d = 1'b0;

      case (state_q)
         ACCUM: begin
            if (pi_cancel) begin
               reject_d = coin_any;
               if (credit_q != '0) begin
                  change_d = credit_q;
                  credit_d = '0;
                  state_d  = REFUND;
               end
            end else if (coin_bad) begin
               reject_d = 1'b1;
            end else if (coin_any) begin
               if (sum >= PRICE) begin
                  cola_d   = 1'b1;
                  credit_d = '0;
                  change_d = CNT_W'(sum - PRICE);
                  state_d  = (sum == PRICE) ? ACCUM : REFUND;
               end else begin
                  credit_d = sum[CNT_W-1:0];
               end
            end
         end

         REFUND: begin
            reject_d = coin_any;
            // Largest coin first; leave on the edge that pays the last one.
            if (change_q >= CNT_W'(2)) begin
               one_d    = 1'b1;
               change_d = change_q - CNT_W'(2);
            end else begin
               half_d   = (change_q == CNT_W'(1));
               change_d = '0;
            end
            state_d = (change_q <= CNT_W'(2)) ? ACCUM : REFUND;
         end

         default: begin
            state_d  = ACCUM;
            change_d = '0;
         end
      endcase
   end

   // NOTE: reset is sampled synchronously and clears pending change, abandoning any refund.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q       <= ACCUM;
         credit_q      <= '0;
         change_q      <= '0;
         po_cola       <= 1'b0;
         po_money_one  <= 1'b0;
         po_money_half <= 1'b0;
         po_reject     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q       <= state_d;
         credit_q      <= credit_d;
         change_q      <= change_d;
         po_cola       <= cola_d;
         po_money_one  <= one_d;
         po_money_half <= half_d;
         po_reject     <= reject_d;
      end
   end

   assign po_credit = credit_q;

endmodule

// File: tb/tb_fsm_vend_refund.sv
// Self-checking bench: four price configurations share one stimulus stream and are
// compared every cycle against a credit / pending-change reference model.
module tb_fsm_vend_refund;

   logic sys_clk = 1'b0;
   logic sys_rst;
   logic pi_money_half, pi_money_one, pi_cancel;
   logic cola [4];
   logic m_one [4];
   logic m_half [4];
   logic rej [4];
   logic [3:0] cr0, cr1, cr3;
   logic [2:0] cr2;

   int total = 0;
   int bad   = 0;

   int price [4] = '{3, 1, 2, 7};
   int m_credit [4];
   int m_pend [4];
   int m_exp [4];

   always #5 sys_clk = ~sys_clk;

   fsm_vend_refund #(.PRICE_HALVES(3), .CNT_W(4)) u_p3 (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .pi_money_half(pi_money_half),
      .pi_money_one(pi_money_one), .pi_cancel(pi_cancel), .po_cola(cola[0]),
      .po_money_one(m_one[0]), .po_money_half(m_half[0]), .po_reject(rej[0]),
      .po_credit(cr0));

   fsm_vend_refund #(.PRICE_HALVES(1), .CNT_W(4)) u_p1 (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .pi_money_half(pi_money_half),
      .pi_money_one(pi_money_one), .pi_cancel(pi_cancel), .po_cola(cola[1]),
      .po_money_one(m_one[1]), .po_money_half(m_half[1]), .po_reject(rej[1]),
      .po_credit(cr1));

   fsm_vend_refund #(.PRICE_HALVES(2), .CNT_W(3)) u_p2 (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .pi_money_half(pi_money_half),
      .pi_money_one(pi_money_one), .pi_cancel(pi_cancel), .po_cola(cola[2]),
      .po_money_one(m_one[2]), .po_money_half(m_half[2]), .po_reject(rej[2]),
      .po_credit(cr2));

   fsm_vend_refund #(.PRICE_HALVES(7), .CNT_W(4)) u_p7 (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .pi_money_half(pi_money_half),
      .pi_money_one(pi_money_one), .pi_cancel(pi_cancel), .po_cola(cola[3]),
      .po_money_one(m_one[3]), .po_money_half(m_half[3]), .po_reject(rej[3]),
      .po_credit(cr3));

   // Outputs folded into one number: cola|one|half|reject in bits 8..5, credit below.
   function automatic int pack(input logic c, input logic o, input logic h,
                               input logic r, input int credit);
      return (int'(c) << 8) | (int'(o) << 7) | (int'(h) << 6) | (int'(r) << 5) | credit;
   endfunction

   function automatic int observe(input int k);
      case (k)
         0:       return pack(cola[0], m_one[0], m_half[0], rej[0], int'(cr0));
         1:       return pack(cola[1], m_one[1], m_half[1], rej[1], int'(cr1));
         2:       return pack(cola[2], m_one[2], m_half[2], rej[2], int'(cr2));
         default: return pack(cola[3], m_one[3], m_half[3], rej[3], int'(cr3));
      endcase
   endfunction

   // Customer-level model: credit owed toward the item, and change still owed back.
   task automatic model_step(input int k, input logic h, input logic o,
                             input logic c, input logic r);
      logic ec, eo, eh, er;
      int   value;
      ec = 1'b0; eo = 1'b0; eh = 1'b0; er = 1'b0;
      value = (o && !h) ? 2 : ((h && !o) ? 1 : 0);
      if (r) begin
         m_credit[k] = 0;
         m_pend[k]   = 0;
      end else if (m_pend[k] > 0) begin
         er = h | o;
         if (m_pend[k] >= 2) begin
            eo = 1'b1;
            m_pend[k] -= 2;
         end else begin
            eh = 1'b1;
            m_pend[k] = 0;
         end
      end else if (c) begin
         er = h | o;
         m_pend[k]   = m_credit[k];
         m_credit[k] = 0;
      end else if (h && o) begin
         er = 1'b1;
      end else if (value > 0) begin
         if (m_credit[k] + value >= price[k]) begin
            ec = 1'b1;
            m_pend[k]   = m_credit[k] + value - price[k];
            m_credit[k] = 0;
         end else begin
            m_credit[k] += value;
         end
      end
      m_exp[k] = pack(ec, eo, eh, er, m_credit[k]);
   endtask

   task automatic cyc(input logic h, input logic o, input logic c, input logic r);
      int got;
      pi_money_half = h;
      pi_money_one  = o;
      pi_cancel     = c;
      sys_rst       = r;
      @(posedge sys_clk);
      for (int k = 0; k < 4; k++) model_step(k, h, o, c, r);
      #1;
      for (int k = 0; k < 4; k++) begin
         got = observe(k);
         total++;
         assert (got === m_exp[k]) else begin
            bad++;
            $error("FAIL outputs price=%0d t=%0t observed=%h expected=%h",
                   price[k], $time, got, m_exp[k]);
         end
      end
   endtask

   initial begin
      pi_money_half = 1'b0;
      pi_money_one  = 1'b0;
      pi_cancel     = 1'b0;
      sys_rst       = 1'b1;
      for (int k = 0; k < 4; k++) begin
         m_credit[k] = 0;
         m_pend[k]   = 0;
      end

      // Reset state.
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 0);

      // Half then one on non-adjacent cycles, then one + one.
      cyc(1, 0, 0, 0); cyc(0, 0, 0, 0); cyc(0, 1, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 1);
      cyc(0, 1, 0, 0); cyc(0, 0, 0, 0); cyc(0, 1, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);

      // Cancel with no credit, illegal coin, coin with cancel.
      cyc(0, 0, 0, 1);
      cyc(0, 0, 1, 0);
      cyc(1, 1, 0, 0);
      cyc(1, 0, 0, 0);
      cyc(0, 1, 1, 0);
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);

      // Credit 6 at price 7, cancel, coins arriving during the refund, coin right after.
      cyc(0, 0, 0, 1);
      cyc(0, 1, 0, 0); cyc(0, 1, 0, 0); cyc(0, 1, 0, 0);
      cyc(0, 0, 1, 0);
      cyc(1, 0, 0, 0); cyc(0, 1, 1, 0); cyc(1, 1, 0, 0);
      cyc(1, 0, 0, 0);
      cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);

      // Reset after the first refund pulse.
      cyc(0, 0, 0, 1);
      cyc(0, 1, 0, 0); cyc(0, 1, 0, 0); cyc(0, 1, 0, 0);
      cyc(0, 0, 1, 0);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 1);
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         cyc(logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 3) == 0),
             logic'($urandom_range(0, 9) == 0), logic'($urandom_range(0, 79) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fsm_vend_refund.md
# fsm_vend_refund

Parametrised coin-operated vending controller. It is the change-giving successor of the team's fixed-price, no-refund cola FSM. The block accepts half-unit and one-unit coins and accumulates credit up to a programmable price. When the price is reached it dispenses one item and returns any overpayment as a serial stream of one-unit and half-unit coin pulses. A cancel input refunds the accumulated credit, and any coin arriving while change is being paid out is rejected.

## Interface
Parameters:
- PRICE_HALVES, 3: item price in half-units; legal range 1 .. 2^CNT_W−2.
- CNT_W, 4: width of the credit and change counters; must hold PRICE_HALVES+1.

Ports:
- sys_clk in 1: single clock; every register updates on its rising edge.
- sys_rst in 1: synchronous, active-high reset.
- pi_money_half in 1: one-cycle pulse; a half-unit coin was inserted.
- pi_money_one in 1: one-cycle pulse; a one-unit coin was inserted.
- pi_cancel in 1: one-cycle pulse; the customer requests a refund of the credit.
- po_cola out 1: one-cycle pulse; dispense one item.
- po_money_one out 1: one-cycle pulse; return one one-unit coin.
- po_money_half out 1: one-cycle pulse; return one half-unit coin.
- po_reject out 1: one-cycle pulse; the coin just inserted was not accepted and is returned.
- po_credit out CNT_W: current accumulated credit, in half-units.

## Operation
Coin value: {pi_money_one, pi_money_half} = 01 is worth 1 half-unit, 10 is worth 2, 00 is no coin, and 11 is illegal.

State machine: two states, ACCUM and REFUND. Reset and illegal encodings go to ACCUM.

Reset (sys_rst=1 at an edge): state=ACCUM, credit=0, change=0, and all outputs are 0. Reset overrides any refund in progress; unpaid change is discarded.

ACCUM (let sum = credit + value):
- Illegal coin (11): ignored; po_reject=1.
- Valid coin with sum < PRICE_HALVES: credit <= sum.
- Valid coin with sum >= PRICE_HALVES:
  - po_cola=1 and credit <= 0.
  - change <= sum − PRICE_HALVES.
  - Go to REFUND if change > 0; otherwise stay in ACCUM.
- pi_cancel=1 with credit > 0: change <= credit, credit <= 0, go to REFUND.
- pi_cancel=1 with credit = 0: no operation.
- pi_cancel together with a coin: cancel wins; the coin is rejected (po_reject=1) and is not added to the credit.

REFUND: one coin is paid out per cycle, largest first.
- change >= 2: po_money_one=1, change <= change − 2.
- change = 1: po_money_half=1, change <= 0.
- Return to ACCUM on the edge where the new change value is 0.
- Any coin (legal or illegal) arriving in REFUND: po_reject=1, and credit is not updated.
- pi_cancel in REFUND: ignored.

Arithmetic: sum is computed at CNT_W+1 bits. Overflow is impossible within the legal PRICE_HALVES range.

po_credit equals the credit register directly.

## Timing
- Every output is registered. A pulse caused by an input sampled at edge N is high for exactly the one cycle after edge N.
- po_cola appears one cycle after the completing coin.
- The first change pulse appears in the cycle after the po_cola pulse, or in the cycle after the cancel pulse.
- Change pulses then follow on consecutive cycles with no gaps. Refunding change c takes ceil(c/2) cycles.
- po_money_one and po_money_half are never high in the same cycle.
- po_cola is never high in the same cycle as a change pulse.
- po_reject can coincide with a change pulse.
- po_credit reflects a coin one cycle after it is inserted. It reads 0 in the cycle po_cola is high.
- A new coin is accepted on the cycle immediately after the last change pulse has been issued, i.e. in the first ACCUM cycle.

## Test plan
- PRICE_HALVES=3; half, then one (on non-adjacent cycles) → po_credit goes 1 then 0; po_cola pulses once; no change pulses; state stays ACCUM.
- PRICE_HALVES=3; one, then one → po_cola pulses, followed the next cycle by exactly one po_money_half pulse; po_credit ends at 0.
- PRICE_HALVES=1; one → po_cola pulses, then one po_money_half pulse. PRICE_HALVES=2 with CNT_W=3; half, then one → po_cola pulses, then one po_money_half pulse.
- PRICE_HALVES=7; one, one, one (credit 6), then cancel → three consecutive po_money_one pulses, then ACCUM with credit 0. A coin inserted during those three cycles gives po_reject=1 and does not change the credit.
- Cancel with credit 0 → no output pulses. An illegal 11 coin, and a coin arriving together with a cancel, each give po_reject=1 with the credit unchanged (the cancel still starts its refund).
- Assert sys_rst in the middle of a REFUND (PRICE_HALVES=7, credit 6, cancel, reset after the first pulse) → all outputs 0 the next cycle; no further change pulses; state ACCUM.
